// File: rtl/seg_pkg.sv
// Shared constants and types for the front-panel seven-segment display.
// Segment codes are active-low and ordered a..g from bit 6 down to bit 0.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_ONE   = 7'h4F;
    localparam seg_t SEG_TWO   = 7'h12;
    localparam seg_t SEG_BLANK = 7'h7F;

    localparam int NUM_DIGITS = 2;

endpackage : seg_pkg

// File: rtl/seg7_decoder.sv
// Maps a clip-select bit to the segment code for "1" or "2".
// A low select means clip 1 and a high select means clip 2.
module seg7_decoder
    import seg_pkg::*;
(
    input  logic clipSel_i,
    output seg_t seg_o
);

    // Only two glyphs are ever needed, so a plain select picks between them.
    assign seg_o = clipSel_i ? SEG_TWO : SEG_ONE;

endmodule : seg7_decoder

// File: rtl/segment_led_interface.sv
// Two-digit multiplexed driver for the common-anode display.
// Digit 0 shows the record-clip switch and digit 1 the play-clip switch.
// Both digits share the cathode bus and are lit in turn for REFRESH_DIV cycles.
module segment_led_interface
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       switch0,
    input  logic       switch1,
    output logic       a0,
    output logic       a1,
    output logic [6:0] cathode
);

    localparam int CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);

    logic [SYNC_STAGES-1:0] syncSw0_q;
    logic [SYNC_STAGES-1:0] syncSw1_q;

    logic [CntW-1:0]       refreshCnt_q, refreshCnt_d;
    logic                  digitSel_q, digitSel_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    seg_t                  cathode_q, cathode_d;

    seg_t segDigit0;
    seg_t segDigit1;

    // Each switch is asynchronous to the clock, so it walks through a short
    // chain of flops before any logic looks at it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            syncSw0_q <= '0;
            syncSw1_q <= '0;
        end else begin
            syncSw0_q[0] <= switch0;
            syncSw1_q[0] <= switch1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                syncSw0_q[i] <= syncSw0_q[i-1];
                syncSw1_q[i] <= syncSw1_q[i-1];
            end
        end
    end

    seg7_decoder u_decDigit0 (
        .clipSel_i (syncSw0_q[SYNC_STAGES-1]),
        .seg_o     (segDigit0)
    );

    seg7_decoder u_decDigit1 (
        .clipSel_i (syncSw1_q[SYNC_STAGES-1]),
        .seg_o     (segDigit1)
    );

    // The refresh counter wraps after REFRESH_DIV cycles and flips the digit
    // select on its last count, so every digit dwells for a full period.
    always_comb begin
        refreshCnt_d = refreshCnt_q + CntW'(1);
        digitSel_d   = digitSel_q;
        if (refreshCnt_q == CntLast) begin
            refreshCnt_d = '0;
            digitSel_d   = ~digitSel_q;
        end
    end

    // The anode and cathode for the currently selected digit are worked out
    // here; the anode is a one-cold vector with the selected digit pulled low.
    always_comb begin
        anode_d   = ~(NUM_DIGITS'(1) << digitSel_q);
        cathode_d = digitSel_q ? segDigit1 : segDigit0;
    end

    // Counter, digit select and display outputs are all registered together;
    // reset blanks the display and restarts the scan at digit 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            refreshCnt_q <= '0;
            digitSel_q   <= 1'b0;
            anode_q      <= '1;
            cathode_q    <= SEG_BLANK;
        end else begin
            refreshCnt_q <= refreshCnt_d;
            digitSel_q   <= digitSel_d;
            anode_q      <= anode_d;
            cathode_q    <= cathode_d;
        end
    end

    assign a0      = anode_q[0];
    assign a1      = anode_q[1];
    assign cathode = cathode_q;

endmodule : segment_led_interface

// File: tb/tb_segment_led_interface.sv
// Self-checking bench for the two-digit display driver.
// Two copies of the driver run side by side from the same switches, one with a
// four-cycle refresh and one with a seven-cycle refresh.
module tb_segment_led_interface;

    localparam int SyncStages = 2;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b1;
    logic       switch0 = 1'b0;
    logic       switch1 = 1'b0;

    logic       dut4A0, dut4A1;
    logic [6:0] dut4Cath;
    logic       dut7A0, dut7A1;
    logic [6:0] dut7Cath;

    int assertCount = 0;
    int failCount   = 0;

    int edgeCount = 0;
    bit swHist0[$];
    bit swHist1[$];

    int dwellRun[4] = '{0, 0, 0, 0};

    segment_led_interface #(
        .REFRESH_DIV (4),
        .SYNC_STAGES (SyncStages)
    ) dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .switch0 (switch0),
        .switch1 (switch1),
        .a0      (dut4A0),
        .a1      (dut4A1),
        .cathode (dut4Cath)
    );

    segment_led_interface #(
        .REFRESH_DIV (7),
        .SYNC_STAGES (SyncStages)
    ) dut7 (
        .clock   (clock),
        .reset_n (reset_n),
        .switch0 (switch0),
        .switch1 (switch1),
        .a0      (dut7A0),
        .a1      (dut7A1),
        .cathode (dut7Cath)
    );

    // 10 ns clock.
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // The model just remembers how many edges have passed since reset was
    // released and what the switches looked like on each of those edges.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            edgeCount = 0;
            swHist0.delete();
            swHist1.delete();
        end else begin
            edgeCount++;
            swHist0.push_back(switch0);
            swHist1.push_back(switch1);
        end
    end

    function automatic logic [6:0] glyph(input bit sw);
        return sw ? 7'h12 : 7'h4F;
    endfunction

    // Expected output of a driver with the given refresh period: the lit digit
    // follows from how many whole dwell periods have elapsed, and it shows the
    // switch value seen SyncStages edges earlier (zero before that exists).
    task automatic compareDut(input string tag, input int div, input logic a0x, input logic a1x, input logic [6:0] cathx);
        logic       expA0, expA1;
        logic [6:0] expCath;
        int         digit, idx;
        bit         sw;
        if (!reset_n || edgeCount == 0) begin
            expA0   = 1'b1;
            expA1   = 1'b1;
            expCath = 7'h7F;
        end else begin
            digit = ((edgeCount - 1) / div) % 2;
            idx   = edgeCount - 1 - SyncStages;
            if (idx >= 0) sw = (digit == 0) ? swHist0[idx] : swHist1[idx];
            else          sw = 1'b0;
            expA0   = (digit != 0);
            expA1   = (digit == 0);
            expCath = glyph(sw);
            checkOutput({tag, "_oneLit"}, {31'd0, a0x ^ a1x}, 32'd1);
        end
        checkOutput({tag, "_a0"}, {31'd0, a0x}, {31'd0, expA0});
        checkOutput({tag, "_a1"}, {31'd0, a1x}, {31'd0, expA1});
        checkOutput({tag, "_cathode"}, {25'd0, cathx}, {25'd0, expCath});
    endtask

    // Every falling edge, both drivers are compared against the model.
    always @(negedge clock) begin
        compareDut("dut4", 4, dut4A0, dut4A1, dut4Cath);
        compareDut("dut7", 7, dut7A0, dut7A1, dut7Cath);
    end

    // Independently of the model, every completed low stretch of each anode
    // must last exactly one refresh period; a reset discards a partial run.
    always @(negedge clock) begin
        logic anodes[4];
        int   divs[4];
        anodes = '{dut4A0, dut4A1, dut7A0, dut7A1};
        divs   = '{4, 4, 7, 7};
        for (int i = 0; i < 4; i++) begin
            if (!reset_n || edgeCount == 0) begin
                dwellRun[i] = 0;
            end else if (anodes[i] == 1'b0) begin
                dwellRun[i]++;
            end else if (dwellRun[i] > 0) begin
                checkOutput($sformatf("dwell%0d", i), dwellRun[i], divs[i]);
                dwellRun[i] = 0;
            end
        end
    end

    task automatic applyStimulus(input bit s0, input bit s1, input int cycles);
        @(posedge clock);
        #3;
        switch0 = s0;
        switch1 = s1;
        repeat (cycles) @(posedge clock);
    endtask

    // Waits (bounded) for the four-cycle driver to light the given digit and
    // checks the glyph it shows there.
    task automatic waitDigit(input int digit, input logic [6:0] expCath, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clock);
            if (((digit == 0) ? dut4A0 : dut4A1) == 1'b0) found = 1'b1;
        end
        if (found) checkOutput(name, {25'd0, dut4Cath}, {25'd0, expCath});
        else       checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Directed sequence with hand-computed expectations at key points.
    initial begin
        #1;
        reset_n = 1'b0;
        switch0 = 1'b1;
        switch1 = 1'b1;
        #44;
        checkOutput("resetA0", {31'd0, dut4A0}, 32'd1);
        checkOutput("resetA1", {31'd0, dut4A1}, 32'd1);
        checkOutput("resetCath", {25'd0, dut4Cath}, 32'h7F);

        @(posedge clock);
        #3;
        switch0 = 1'b0;
        switch1 = 1'b0;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("firstEdgeA0", {31'd0, dut4A0}, 32'd0);
        checkOutput("firstEdgeA1", {31'd0, dut4A1}, 32'd1);
        checkOutput("firstEdgeCath", {25'd0, dut4Cath}, 32'h4F);

        applyStimulus(1'b0, 1'b0, 20);
        waitDigit(0, 7'h4F, "sw00_digit0");
        waitDigit(1, 7'h4F, "sw00_digit1");

        applyStimulus(1'b1, 1'b0, 16);
        waitDigit(0, 7'h12, "sw10_digit0");
        waitDigit(1, 7'h4F, "sw10_digit1");

        applyStimulus(1'b0, 1'b1, 16);
        waitDigit(0, 7'h4F, "sw01_digit0");
        waitDigit(1, 7'h12, "sw01_digit1");

        applyStimulus(1'b1, 1'b1, 16);
        waitDigit(0, 7'h12, "sw11_digit0");
        waitDigit(1, 7'h12, "sw11_digit1");

        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("midResetA0", {31'd0, dut4A0}, 32'd1);
        checkOutput("midResetA1", {31'd0, dut4A1}, 32'd1);
        checkOutput("midResetCath", {25'd0, dut4Cath}, 32'h7F);
        checkOutput("midReset7Cath", {25'd0, dut7Cath}, 32'h7F);
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("resumeA0", {31'd0, dut4A0}, 32'd0);
        checkOutput("resumeA1", {31'd0, dut4A1}, 32'd1);
        checkOutput("resume7A0", {31'd0, dut7A0}, 32'd0);

        applyStimulus(1'b0, 1'b1, 9);
        applyStimulus(1'b1, 1'b0, 11);
        applyStimulus(1'b0, 1'b0, 30);
        applyStimulus(1'b1, 1'b1, 4);

        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule : tb_segment_led_interface
